// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: paces the TX shifter, bit-stuffs and NRZI-encodes its serial
// stream onto D+/D-, then appends SE0,SE0,J and returns the line to idle.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LEN = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic start,
  input  logic serial_in,
  input  logic tx_more,
  output logic load_strobe,
  output logic shift_strobe,
  output logic halt,
  output logic d_plus,
  output logic d_minus,
  output logic busy,
  output logic eop_done
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int OW = $clog2(STUFF_LEN + 1);
  typedef enum logic [2:0] {IDLE, LOAD, DATA, STUFF, EOP_SE0, EOP_J} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0] bit_q, bit_d;
  logic [OW-1:0] ones_q, ones_d;
  logic end_q, end_d, se0_q, se0_d, dp_q, dp_d, dm_q, dm_d;
  logic t0, tl, last;
  assign t0 = timer_q == '0;
  assign tl = timer_q == TW'(CLKS_PER_BIT - 1);
  assign last = tl && bit_q == 3'd7 && !tx_more;
  assign d_plus = dp_q;
  assign d_minus = dm_q;
  assign busy = state_q != IDLE;
  assign halt = state_q == STUFF;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q <= '0;
      ones_q <= '0;
      end_q <= 1'b0;
      se0_q <= 1'b0;
      dp_q <= 1'b1;
      dm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q <= bit_d;
      ones_q <= ones_d;
      end_q <= end_d;
      se0_q <= se0_d;
      dp_q <= dp_d;
      dm_q <= dm_d;
    end
  end
  always_comb begin
    state_d = state_q;
    timer_d = (state_q == IDLE || state_q == LOAD || tl) ? '0 : timer_q + 1'b1;
    bit_d = bit_q;
    ones_d = ones_q;
    end_d = end_q;
    se0_d = se0_q;
    dp_d = dp_q;
    dm_d = dm_q;
    load_strobe = 1'b0;
    shift_strobe = 1'b0;
    eop_done = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        ones_d = '0;
        bit_d = '0;
      end
      LOAD: begin
        load_strobe = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        if (t0) begin
          {dp_d, dm_d} = serial_in ? {dp_q, dm_q} : {dm_q, dp_q};
          ones_d = serial_in ? ones_q + 1'b1 : '0;
        end
        if (tl) begin
          bit_d = bit_q + 1'b1;
          shift_strobe = bit_q != 3'd7;
          load_strobe = bit_q == 3'd7 && tx_more;
          end_d = end_q | last;
          // stuffing takes priority; a pending end is kept for after the stuff bit
          state_d = ones_q == OW'(STUFF_LEN) ? STUFF : (end_q | last) ? EOP_SE0 : DATA;
        end
      end
      STUFF: begin
        if (t0) begin
          {dp_d, dm_d} = {dm_q, dp_q};
          ones_d = '0;
        end
        if (tl) state_d = end_q ? EOP_SE0 : DATA;
      end
      EOP_SE0: begin
        if (t0) {dp_d, dm_d} = 2'b00;
        if (tl) begin
          se0_d = !se0_q;
          state_d = se0_q ? EOP_J : EOP_SE0;
        end
      end
      EOP_J: begin
        if (t0) {dp_d, dm_d} = 2'b10;
        if (tl) begin
          state_d = IDLE;
          eop_done = 1'b1;
          end_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: random and directed packets through a shifter model; a
// monitor checks the line per bit period against a queue of expected symbols.
module tb_usb_tx_encoder;
  localparam int CPB = 8;
  localparam int SL = 6;
  logic clk = 1'b0, n_rst = 1'b0, start = 1'b0;
  logic serial_in, tx_more, load_strobe, shift_strobe, halt, d_plus, d_minus, busy, eop_done;
  typedef struct {int off; logic [1:0] v;} ent_t;
  typedef struct {int off; int sh; int ld; int hl;} pkt_t;
  ent_t line_q[$];
  pkt_t pkt_q[$];
  logic [7:0] bytes[$];
  logic [7:0] sh;
  int rd = 0, nb = 0;
  int total = 0, bad = 0, viol = 0, eops = 0;
  bit in_pkt = 0;
  int off, n_sh, n_ld, n_hl;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB), .STUFF_LEN(SL)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .serial_in(serial_in), .tx_more(tx_more),
    .load_strobe(load_strobe), .shift_strobe(shift_strobe), .halt(halt),
    .d_plus(d_plus), .d_minus(d_minus), .busy(busy), .eop_done(eop_done)
  );

  always #5 clk = ~clk;

  assign serial_in = sh[0];
  assign tx_more = rd < nb;
  always @(posedge clk) begin
    if (start && !busy) rd <= 0;
    else if (load_strobe) begin
      sh <= bytes[rd];
      rd <= rd + 1;
    end else if (shift_strobe) sh <= sh >> 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: stuffed bit list, NRZI from J, then SE0,SE0,J; one symbol per bit period
  task automatic model();
    int bits[$];
    int ones = 0, nst = 0;
    logic [1:0] lv = 2'b10;
    ent_t e;
    pkt_t p;
    for (int i = 0; i < bytes.size(); i++)
      for (int j = 0; j < 8; j++) begin
        bits.push_back(int'((bytes[i] >> j) & 8'h1));
        ones = ((bytes[i] >> j) & 8'h1) != 0 ? ones + 1 : 0;
        if (ones == SL) begin
          bits.push_back(0);
          ones = 0;
          nst++;
        end
      end
    for (int k = 0; k < bits.size(); k++) begin
      if (bits[k] == 0) lv = ~lv;
      e.off = 5 + CPB * k;
      e.v = lv;
      line_q.push_back(e);
    end
    for (int k = 0; k < 3; k++) begin
      e.off = 5 + CPB * (bits.size() + k);
      e.v = k < 2 ? 2'b00 : 2'b10;
      line_q.push_back(e);
    end
    p.off = CPB * (bits.size() + 3);
    p.sh = 7 * bytes.size();
    p.ld = bytes.size();
    p.hl = CPB * nst;
    pkt_q.push_back(p);
  endtask

  always @(negedge clk) begin
    if (!n_rst) in_pkt = 0;
    else begin
      if ((load_strobe && shift_strobe) || ((load_strobe || shift_strobe) && halt) || (d_plus && d_minus))
        viol++;
      if (in_pkt) begin
        off++;
        n_sh += int'(shift_strobe);
        n_ld += int'(load_strobe);
        n_hl += int'(halt);
      end else if (load_strobe) begin
        in_pkt = 1;
        off = 0;
        n_sh = 0;
        n_ld = 1;
        n_hl = 0;
      end
      if (in_pkt && line_q.size() > 0 && line_q[0].off == off) begin
        ent_t e;
        e = line_q.pop_front();
        chk($sformatf("line@%0d", off), int'({d_plus, d_minus}), int'(e.v));
      end
      if (eop_done) begin
        eops++;
        if (pkt_q.size() == 0) chk("unexpected_eop", 1, 0);
        else begin
          pkt_t p;
          p = pkt_q.pop_front();
          chk("eop_offset", off, p.off);
          chk("shift_count", n_sh, p.sh);
          chk("load_count", n_ld, p.ld);
          chk("halt_cycles", n_hl, p.hl);
          chk("line_left", line_q.size(), 0);
        end
        in_pkt = 0;
      end
    end
  end

  task automatic send(input bit extra);
    int n = 0;
    nb = bytes.size();
    model();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    if (extra) begin
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("pkt_finished", int'(busy), 0);
    repeat (4) @(negedge clk);
    chk("idle_after", int'(busy), 0);
    chk("idle_line", int'({d_plus, d_minus}), 2);
  endtask

  initial begin
    int stuck = 0, n = 0, e0;
    repeat (3) @(negedge clk);
    chk("rst_line", int'({d_plus, d_minus}), 2);
    chk("rst_busy", int'(busy), 0);
    chk("rst_strobes", int'({load_strobe, shift_strobe, halt, eop_done}), 0);
    n_rst = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if ({d_plus, d_minus, busy, load_strobe, shift_strobe, halt, eop_done} != 7'b1000000) stuck++;
    end
    chk("idle_100", stuck, 0);
    bytes.delete(); bytes.push_back(8'h80); send(0);
    bytes.delete(); bytes.push_back(8'h3F); send(0);
    bytes.delete(); bytes.push_back(8'hFC); send(0);
    bytes.delete(); bytes.push_back(8'hFF); bytes.push_back(8'h00); send(0);
    for (int i = 0; i < 8; i++) begin
      bytes.delete();
      for (int j = 0; j < int'($urandom_range(1, 3)); j++)
        bytes.push_back($urandom_range(0, 1) != 0 ? 8'($urandom) : 8'($urandom) | 8'hF8);
      send(0);
    end
    bytes.delete(); bytes.push_back(8'hA5); bytes.push_back(8'h7E); send(1);
    bytes.delete(); bytes.push_back(8'h55); bytes.push_back(8'h0F);
    nb = 2;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (n < 3 && stuck < 200) begin
      @(negedge clk);
      stuck++;
      n += int'(shift_strobe);
    end
    chk("reach_bit3", n, 3);
    repeat (3) @(negedge clk);
    e0 = eops;
    n_rst = 1'b0;
    #1;
    chk("midrst_line", int'({d_plus, d_minus}), 2);
    chk("midrst_busy", int'(busy), 0);
    line_q.delete();
    pkt_q.delete();
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (150) @(negedge clk);
    chk("midrst_no_eop", eops - e0, 0);
    bytes.delete(); bytes.push_back(8'hC3); send(0);
    chk("violations", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
